// File: rtl/link_monitor.sv
// rtl/link_monitor.sv - fibre link rx status: byte history, lock FSM, saturating counters, status LEDs
// Optional build macro LINK_MON_PRBS_CHECK_EN adds a self-synchronising PRBS-7 bit-error checker.
module link_monitor #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = 16,
   parameter int LOCK_COUNT = 16,
   parameter int TIMEOUT    = 1048576,
   parameter int BLINK_W    = 24,
   localparam int SEL_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d_in,
   input  logic              d_in_valid,
   input  logic              reframe,
   input  logic              clear_counts,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] d_sel,
   output logic [1:0]        link_state,
   output logic [CNT_W-1:0]  byte_count,
   output logic [CNT_W-1:0]  reframe_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              data_led,
   output logic              reframe_led,
   output logic              lock_led
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      NO_LINK = 2'd0,
      SYNCING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // A word that arrives together with a reframe is discarded.
   logic accept;
   assign accept = d_in_valid && !reframe;

   logic [DATA_W-1:0] hist_q [DEPTH];
   logic [DATA_W-1:0] hist_d [DEPTH];
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              timeout;
   state_t            state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [RUN_W-1:0]  run_inc;
   logic [CNT_W-1:0]  byte_count_q, byte_count_d;
   logic [CNT_W-1:0]  reframe_count_q, reframe_count_d;
   logic [BLINK_W-1:0] blink_q, blink_d;
   logic              data_led_q, data_led_d;
   logic              reframe_led_q, reframe_led_d;
   logic              lock_led_q, lock_led_d;

   // History shift register: newest accepted word enters slot 0.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = hist_q[i];
      if (accept) begin
         hist_d[0] = d_in;
         for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      end
   end

   // Idle counter: counts strobe-free cycles, saturating at TIMEOUT.
   always_comb begin
      idle_d  = idle_q;
      timeout = 1'b0;
      if (d_in_valid || reframe) begin
         idle_d = '0;
      end else begin
         if (idle_q != IDLE_W'(TIMEOUT)) idle_d = idle_q + IDLE_W'(1);
         timeout = (idle_d == IDLE_W'(TIMEOUT));
      end
   end

   // Lock FSM next state and run length of consecutive clean words.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      run_inc = ((state_q == NO_LINK) ? '0 : run_q) + RUN_W'(1);
      case (state_q)
         NO_LINK: begin
            if (reframe) begin
               state_d = SYNCING;
               run_d   = '0;
            end else if (d_in_valid) begin
               run_d   = run_inc;
               state_d = (run_inc == RUN_W'(LOCK_COUNT)) ? LOCKED : SYNCING;
            end
         end
         SYNCING: begin
            if (reframe) begin
               run_d = '0;
            end else if (d_in_valid) begin
               run_d = run_inc;
               if (run_inc == RUN_W'(LOCK_COUNT)) state_d = LOCKED;
            end else if (timeout) begin
               state_d = NO_LINK;
               run_d   = '0;
            end
         end
         LOCKED: begin
            if (reframe) begin
               state_d = SYNCING;
               run_d   = '0;
            end else if (timeout) begin
               state_d = NO_LINK;
               run_d   = '0;
            end
         end
         default: begin
            state_d = NO_LINK;
            run_d   = '0;
         end
      endcase
   end

   // Event counters; a clear overrides any increment in the same cycle.
   always_comb begin
      byte_count_d    = byte_count_q;
      reframe_count_d = reframe_count_q;
      if (clear_counts) begin
         byte_count_d    = '0;
         reframe_count_d = '0;
      end else begin
         if (accept)  byte_count_d    = sat_add(byte_count_q, CNT_W'(1));
         if (reframe) reframe_count_d = sat_add(reframe_count_q, CNT_W'(1));
      end
   end

   // LEDs sample the blink phase on activity and hold between events.
   always_comb begin
      blink_d       = blink_q + BLINK_W'(1);
      data_led_d    = data_led_q;
      reframe_led_d = reframe_led_q;
      if (reframe) begin
         data_led_d    = 1'b0;
         reframe_led_d = blink_q[BLINK_W-1];
      end else if (d_in_valid) begin
         data_led_d    = blink_q[BLINK_W-1];
         reframe_led_d = 1'b0;
      end
      lock_led_d = (state_d == LOCKED);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
         idle_q          <= '0;
         state_q         <= NO_LINK;
         run_q           <= '0;
         byte_count_q    <= '0;
         reframe_count_q <= '0;
         blink_q         <= '0;
         data_led_q      <= 1'b0;
         reframe_led_q   <= 1'b0;
         lock_led_q      <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
         idle_q          <= idle_d;
         state_q         <= state_d;
         run_q           <= run_d;
         byte_count_q    <= byte_count_d;
         reframe_count_q <= reframe_count_d;
         blink_q         <= blink_d;
         data_led_q      <= data_led_d;
         reframe_led_q   <= reframe_led_d;
         lock_led_q      <= lock_led_d;
      end
   end

`ifdef LINK_MON_PRBS_CHECK_EN
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic              skip_q, skip_d;
   logic [DATA_W-1:0] prbs_exp;

   // Expected PRBS-7 word continuing the bit stream of the previous word (MSB sent first).
   function automatic logic [DATA_W-1:0] prbs_next(input logic [DATA_W-1:0] prev);
      logic [6:0]        st;
      logic              nb;
      logic [DATA_W-1:0] w;
      st = prev[6:0];
      w  = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         nb   = st[5] ^ st[6];
         w[i] = nb;
         st   = {st[5:0], nb};
      end
      return w;
   endfunction

   // Bit-error accumulation; the first word after gaining lock only seeds the checker.
   always_comb begin
      prbs_exp    = prbs_next(hist_q[0]);
      err_count_d = err_count_q;
      skip_d      = skip_q;
      if (state_q != LOCKED)  skip_d = 1'b1;
      else if (accept)        skip_d = 1'b0;
      if (clear_counts)
         err_count_d = '0;
      else if (accept && state_q == LOCKED && !skip_q)
         err_count_d = sat_add(err_count_q, CNT_W'($countones(d_in ^ prbs_exp)));
   end

   // Checker registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_q <= '0;
         skip_q      <= 1'b1;
      end else begin
         err_count_q <= err_count_d;
         skip_q      <= skip_d;
      end
   end

   assign err_count = err_count_q;
`else
   assign err_count = '0;
`endif

   assign d_sel         = hist_q[sel];
   assign link_state    = state_q;
   assign byte_count    = byte_count_q;
   assign reframe_count = reframe_count_q;
   assign data_led      = data_led_q;
   assign reframe_led   = reframe_led_q;
   assign lock_led      = lock_led_q;

endmodule

// File: tb/tb_link_monitor.sv
// tb/tb_link_monitor.sv - directed self-checking bench for link_monitor
module tb_link_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d_in;
   logic       d_in_valid;
   logic       reframe;
   logic       clear_counts;
   logic [1:0] sel;
   logic       s_valid;
   logic       s_clear;

   logic [7:0]  d_sel;
   logic [1:0]  link_state;
   logic [15:0] byte_count;
   logic [15:0] reframe_count;
   logic [15:0] err_count;
   logic        data_led;
   logic        reframe_led;
   logic        lock_led;

   logic [7:0]  s_d_sel;
   logic [1:0]  s_link_state;
   logic [3:0]  s_byte_count;
   logic [3:0]  s_reframe_count;
   logic [3:0]  s_err_count;
   logic        s_data_led;
   logic        s_reframe_led;
   logic        s_lock_led;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic blink_at_edge = 1'b0;

   always #5 clk = ~clk;

   link_monitor #(
      .DATA_W(8), .DEPTH(4), .CNT_W(16), .LOCK_COUNT(16), .TIMEOUT(100), .BLINK_W(4)
   ) u_main (
      .clk(clk), .rst(rst), .d_in(d_in), .d_in_valid(d_in_valid), .reframe(reframe),
      .clear_counts(clear_counts), .sel(sel), .d_sel(d_sel), .link_state(link_state),
      .byte_count(byte_count), .reframe_count(reframe_count), .err_count(err_count),
      .data_led(data_led), .reframe_led(reframe_led), .lock_led(lock_led)
   );

   link_monitor #(
      .DATA_W(8), .DEPTH(4), .CNT_W(4), .LOCK_COUNT(16), .TIMEOUT(100), .BLINK_W(4)
   ) u_small (
      .clk(clk), .rst(rst), .d_in(d_in), .d_in_valid(s_valid), .reframe(1'b0),
      .clear_counts(s_clear), .sel(sel), .d_sel(s_d_sel), .link_state(s_link_state),
      .byte_count(s_byte_count), .reframe_count(s_reframe_count), .err_count(s_err_count),
      .data_led(s_data_led), .reframe_led(s_reframe_led), .lock_led(s_lock_led)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cyc tracks the DUT blink counter (BLINK_W=4); blink_at_edge is its MSB sampled at the edge
   task automatic tick();
      @(posedge clk);
      blink_at_edge = cyc[3];
      if (rst) cyc = 0;
      else     cyc = (cyc + 1) % 16;
      #1;
   endtask

   task automatic send(input logic [7:0] w);
      d_in = w;
      d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
   endtask

   task automatic chk_hist(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      sel = 2'd0; #1; chk({tag, "_h0"}, d_sel, e0);
      sel = 2'd1; #1; chk({tag, "_h1"}, d_sel, e1);
      sel = 2'd2; #1; chk({tag, "_h2"}, d_sel, e2);
      sel = 2'd3; #1; chk({tag, "_h3"}, d_sel, e3);
      sel = 2'd0;
   endtask

   // Bit-serial PRBS-7 continuation: b[n] = b[n-6] ^ b[n-7], MSB of each word first
   function automatic logic [7:0] next_word(input logic [7:0] prev);
      logic b [16];
      logic [7:0] w;
      for (int i = 0; i < 8; i++) b[i] = prev[7-i];
      for (int n = 8; n < 16; n++) b[n] = b[n-6] ^ b[n-7];
      for (int i = 0; i < 8; i++) w[7-i] = b[8+i];
      return w;
   endfunction

   initial begin
      rst = 1'b1; d_in = 8'h00; d_in_valid = 1'b0; reframe = 1'b0;
      clear_counts = 1'b0; sel = 2'd0; s_valid = 1'b0; s_clear = 1'b0;

      // reset state
      tick();
      rst = 1'b0;
      chk("rst_state", link_state, 2'd0);
      chk("rst_bytes", byte_count, 0);
      chk("rst_refr", reframe_count, 0);
      chk("rst_leds", {data_led, reframe_led, lock_led}, 3'b000);
      chk_hist("rst", 8'h00, 8'h00, 8'h00, 8'h00);

      // 16 consecutive words lock the link
      for (int i = 1; i <= 15; i++) send(8'(i));
      chk("sync_15", link_state, 2'd1);
      chk("lockled_15", lock_led, 1'b0);
      send(8'h10);
      chk("lock_16", link_state, 2'd2);
      chk("lockled_16", lock_led, 1'b1);
      chk("bytes_16", byte_count, 16);
      chk("data_led_16", data_led, blink_at_edge);
      chk_hist("lock", 8'h10, 8'h0F, 8'h0E, 8'h0D);
      chk("err_clean_lock", err_count, 0);

      // reframe while locked, timed so the blink phase is high
      while (cyc[3] !== 1'b1) tick();
      reframe = 1'b1;
      tick();
      reframe = 1'b0;
      chk("refr_state", link_state, 2'd1);
      chk("refr_count", reframe_count, 1);
      chk("refr_led", reframe_led, 1'b1);
      chk("refr_dataled", data_led, 1'b0);
      chk("refr_lockled", lock_led, 1'b0);
      send(8'h21);
      chk("refr_led_clr", reframe_led, 1'b0);
      chk("data_led_back", data_led, blink_at_edge);
      for (int i = 2; i <= 15; i++) send(8'(8'h20 + i));
      chk("resync_15", link_state, 2'd1);
      send(8'h30);
      chk("relock_16", link_state, 2'd2);
      chk("bytes_32", byte_count, 32);

      // valid and reframe together: word dropped, reframe counted
      d_in = 8'hAA; d_in_valid = 1'b1; reframe = 1'b1;
      tick();
      d_in_valid = 1'b0; reframe = 1'b0;
      chk("both_state", link_state, 2'd1);
      chk("both_bytes", byte_count, 32);
      chk("both_refr", reframe_count, 2);
      chk_hist("both", 8'h30, 8'h2F, 8'h2E, 8'h2D);

      // idle timeout boundary
      for (int i = 1; i <= 16; i++) send(8'(8'h40 + i));
      chk("lock_again", link_state, 2'd2);
      repeat (99) tick();
      chk("idle99_locked", link_state, 2'd2);
      send(8'h51);
      chk("idle_valid_locked", link_state, 2'd2);
      repeat (99) tick();
      chk("idle99b_locked", link_state, 2'd2);
      tick();
      chk("timeout_state", link_state, 2'd0);
      chk("timeout_lockled", lock_led, 1'b0);
      chk("bytes_49", byte_count, 49);

      // clear_counts zeroes counters but leaves history and FSM alone
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
      chk("clr_bytes", byte_count, 0);
      chk("clr_refr", reframe_count, 0);
      chk("clr_state", link_state, 2'd0);
      chk_hist("clr", 8'h51, 8'h50, 8'h4F, 8'h4E);
      clear_counts = 1'b1; reframe = 1'b1;
      tick();
      clear_counts = 1'b0; reframe = 1'b0;
      chk("clr_refr_coinc", reframe_count, 0);
      chk("clr_refr_fsm", link_state, 2'd1);

      // 4-bit counters saturate at 15
      s_valid = 1'b1;
      repeat (20) tick();
      chk("sat_bytes", s_byte_count, 4'hF);
      s_clear = 1'b1;
      tick();
      s_clear = 1'b0;
      chk("sat_clr_coinc", s_byte_count, 4'h0);
      tick();
      s_valid = 1'b0;
      chk("sat_after_clr", s_byte_count, 4'h1);

      // reset in the middle of traffic
      send(8'h61);
      send(8'h62);
      chk("pre_rst_bytes", byte_count, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_state", link_state, 2'd0);
      chk("mid_rst_bytes", byte_count, 0);
      chk("mid_rst_leds", {data_led, reframe_led, lock_led}, 3'b000);
      chk_hist("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);

`ifdef LINK_MON_PRBS_CHECK_EN
      begin
         logic [7:0] clean;
         logic [7:0] sent;
         logic [7:0] prev_sent;
         int exp_err;

         // clean PRBS stream: no errors
         clean = 8'h5A;
         for (int k = 1; k <= 30; k++) begin
            send(clean);
            clean = next_word(clean);
         end
         chk("prbs_clean_state", link_state, 2'd2);
         chk("prbs_clean_err", err_count, 0);

         // corrupted stream: words 20 (bit 0) and 30 (bit 7) flipped
         rst = 1'b1;
         tick();
         rst = 1'b0;
         clean = 8'h5A;
         prev_sent = 8'h00;
         exp_err = 0;
         for (int k = 1; k <= 40; k++) begin
            sent = clean;
            if (k == 20) sent = sent ^ 8'h01;
            if (k == 30) sent = sent ^ 8'h80;
            if (k >= 18) exp_err += $countones(sent ^ next_word(prev_sent));
            send(sent);
            prev_sent = sent;
            clean = next_word(clean);
         end
         chk("prbs_err", err_count, exp_err);
         clear_counts = 1'b1;
         tick();
         clear_counts = 1'b0;
         chk("prbs_err_clr", err_count, 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
